mem_bus_sequencer: RTL
======================

MEM_BUS_SEQUENCER -- requirements
Module: mem_bus_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0, req1  input  1 each  transaction request; port 0 is instruction fetch, port 1 is data.
REQ-005 we0, we1  input  1 each  1 = write, 0 = read.
REQ-006 addr0, addr1  input  32 each  word address.
REQ-007 wdata0, wdata1  input  32 each  write data.
REQ-008 ack0, ack1  output  1 each  one-cycle completion pulse.
REQ-009 rdata0, rdata1  output  32 each  read result.
REQ-010 pin_addr_out  output  8  serialized address byte.
REQ-011 pin_data_out  output  8  serialized write-data byte.
REQ-012 pin_data_in  input  8  serialized read-data byte.
REQ-013 pin_oe  output  1  data-pin drive enable.
REQ-014 pin_frame  output  1  high on beat 0 of the address phase.
REQ-015 pin_we  output  1  latched we, valid for the whole transaction.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, XFER, TURN, RDATA and DONE, with a 2-bit beat counter.
REQ-018 IDLE SHALL accept a request in any cycle where req0 or req1 is high, latch the winner's we, addr and wdata and its port id, clear the beat counter, and go to XFER.
REQ-019 Arbitration without RR_ARB_EN SHALL be fixed priority, with port 1 winning when both ports request.
REQ-020 XFER beat n (n = 0..3) SHALL drive pin_addr_out = addr[8n+7:8n]; for writes it SHALL also drive pin_data_out = wdata[8n+7:8n] with pin_oe = 1. Transfer is LSB first.
REQ-021 For reads, pin_oe and pin_data_out SHALL be 0 in every state.
REQ-022 After beat 3, a write SHALL go to DONE and a read SHALL go to TURN.
REQ-023 TURN SHALL last one cycle with no pin drive, then go to RDATA.
REQ-024 RDATA beat n SHALL capture pin_data_in into shift[8n+7:8n]; after beat 3 the FSM SHALL go to DONE.
REQ-025 DONE SHALL pulse ack of the latched port for exactly one cycle, then return to IDLE.
REQ-026 On a read, DONE SHALL update that port's rdata, which is valid in the ack cycle and held until that port's next read completes.
REQ-027 Latency from the acceptance cycle to the ack cycle SHALL be 5 cycles for a write and 10 cycles for a read.
REQ-028 A requester SHALL hold req high until ack. Deasserting req, or changing the request fields, after acceptance SHALL NOT affect the transaction in flight.
REQ-029 Requests SHALL NOT be accepted outside IDLE. A req high in the DONE cycle SHALL be evaluated in the following IDLE cycle, so there is at least one idle cycle between transactions.
REQ-030 pin_addr_out, pin_data_out and pin_frame SHALL be 0 outside XFER.

Reset
REQ-031 While rst is high at a clock edge, the block SHALL enter IDLE and clear the beat counter, latches, rdata0/1, ack0/1, all pin outputs and busy.
REQ-032 Reset during a transaction SHALL abort it with no ack, and the aborted port's rdata SHALL read 0.
REQ-033 The first request SHALL be accepted on the first edge after rst deasserts.

Configuration
REQ-034 Macro RR_ARB_EN SHALL select the arbitration scheme.
REQ-035 With RR_ARB_EN defined, simultaneous requests SHALL be granted round-robin: the port not served last wins. A 1-bit last-grant register, reset to 1, SHALL make port 0 win the first tie.
REQ-036 Without RR_ARB_EN, REQ-019 applies and the last-grant register SHALL NOT exist.

Verification
REQ-037 Port 1 write, addr 0x12345678, wdata 0xCAFEBABE -> pin_addr_out sequence 78, 56, 34, 12 with pin_data_out BE, BA, FE, CA; pin_oe = 1 and pin_frame = 1 on the first beat only; ack1 exactly 5 cycles after acceptance.
REQ-038 Port 0 read, addr 0x00000010, pin_data_in 0xEF, 0xBE, 0xAD, 0xDE over the RDATA beats -> rdata0 = 0xDEADBEEF in the ack0 cycle (10 cycles after acceptance); pin_oe = 0 throughout.
REQ-039 req0 and req1 both held high for two transactions -> without the macro, port 1 is served twice; with RR_ARB_EN, port 0 is served then port 1.
REQ-040 rst pulsed on the second RDATA beat -> no ack, busy = 0 and rdata0 = 0 the next cycle; a new request is accepted on the following edge.
REQ-041 req1 dropped after acceptance and addr1 changed to 0xFFFFFFFF -> the original address is still serialized and ack1 still pulses.
REQ-042 req0 high during the DONE cycle of a port 1 transaction -> it is accepted one cycle later (IDLE), and ack0 and ack1 never pulse in the same cycle.

Source files
------------

// File: rtl/mem_bus_sequencer.sv
// Two-port (instruction fetch / data) sequencer onto a byte-serial memory pin bus.
// Define RR_ARB_EN for round-robin arbitration on simultaneous requests; default is fixed port-1 priority.
module mem_bus_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [7:0]  pin_addr_out,
    output logic [7:0]  pin_data_out,
    input  logic [7:0]  pin_data_in,
    output logic        pin_oe,
    output logic        pin_frame,
    output logic        pin_we,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_XFER  = 3'd1,
        S_TURN  = 3'd2,
        S_RDATA = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_beat;
    logic        r_we;
    logic        r_port;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [23:0] r_shift;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;

    logic        w_req_any;
    logic        w_grant;
    logic        w_last_beat;
    logic [4:0]  w_lsb;
    logic [31:0] w_rd_word;

    assign w_req_any   = req0 | req1;
    assign w_last_beat = (r_beat == 2'd3);
    assign w_lsb       = {r_beat, 3'b000};
    // Final read byte joins the three already shifted in, so no 4th shift slot is needed.
    assign w_rd_word   = {pin_data_in, r_shift};

`ifdef RR_ARB_EN
    logic r_last_grant;

    assign w_grant = (req0 & req1) ? ~r_last_grant : req1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (r_state == S_IDLE && w_req_any) begin
            r_last_grant <= w_grant;
        end
    end
`else
    assign w_grant = req1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_req_any) w_next_state = S_XFER;
            S_XFER:  if (w_last_beat) w_next_state = r_we ? S_DONE : S_TURN;
            S_TURN:  w_next_state = S_RDATA;
            S_RDATA: if (w_last_beat) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Request latch, beat counter and read capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat   <= 2'd0;
            r_we     <= 1'b0;
            r_port   <= 1'b0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_shift  <= 24'd0;
            r_rdata0 <= 32'd0;
            r_rdata1 <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_any) begin
                        r_port  <= w_grant;
                        r_we    <= w_grant ? we1    : we0;
                        r_addr  <= w_grant ? addr1  : addr0;
                        r_wdata <= w_grant ? wdata1 : wdata0;
                        r_beat  <= 2'd0;
                    end
                end
                S_XFER: begin
                    r_beat <= r_beat + 2'd1;
                end
                S_TURN: begin
                    r_beat <= 2'd0;
                end
                S_RDATA: begin
                    r_beat  <= r_beat + 2'd1;
                    r_shift <= {pin_data_in, r_shift[23:8]};
                    if (w_last_beat) begin
                        if (r_port) r_rdata1 <= w_rd_word;
                        else        r_rdata0 <= w_rd_word;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        ack0         = 1'b0;
        ack1         = 1'b0;
        pin_addr_out = 8'd0;
        pin_data_out = 8'd0;
        pin_oe       = 1'b0;
        pin_frame    = 1'b0;
        busy         = (r_state != S_IDLE);
        pin_we       = r_we & busy;
        case (r_state)
            S_XFER: begin
                pin_addr_out = r_addr[w_lsb +: 8];
                pin_frame    = (r_beat == 2'd0);
                if (r_we) begin
                    pin_data_out = r_wdata[w_lsb +: 8];
                    pin_oe       = 1'b1;
                end
            end
            S_DONE: begin
                ack0 = ~r_port;
                ack1 = r_port;
            end
            default: begin
            end
        endcase
    end

    assign rdata0 = r_rdata0;
    assign rdata1 = r_rdata1;

endmodule
